// File: rtl/ysyx_lsu_pkg.sv
// Shared LSU definitions: load FSM states, load ALU codes and the load extend helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ysyx_lsu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        LDU_IDLE  = 3'd0,
        LDU_ADDR  = 3'd1,
        LDU_DATA  = 3'd2,
        LDU_RESP  = 3'd3,
        LDU_DRAIN = 3'd4
    } ldu_state_e;

    // Load ALU codes, mirroring the core-wide YSYX_ALU_* defines.
    localparam logic [4:0] ALU_LB  = 5'd16;
    localparam logic [4:0] ALU_LH  = 5'd17;
    localparam logic [4:0] ALU_LW  = 5'd18;
    localparam logic [4:0] ALU_LBU = 5'd19;
    localparam logic [4:0] ALU_LHU = 5'd20;

    // Select and extend the addressed byte/halfword of a word. LW and unknown codes
    // pass the word through untouched.
    function automatic logic [XLEN-1:0] ld_extend(input logic [XLEN-1:0] word,
                                                  input logic [4:0]      alu,
                                                  input logic [1:0]      off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (alu)
            ALU_LB:  r = {{(XLEN-8){b[7]}}, b};
            ALU_LBU: r = {{(XLEN-8){1'b0}}, b};
            ALU_LH:  r = {{(XLEN-16){h[15]}}, h};
            ALU_LHU: r = {{(XLEN-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Halfword loads need an even offset, word loads a zero offset.
    function automatic logic ld_misaligned(input logic [4:0] alu, input logic [1:0] off);
        logic m;
        case (alu)
            ALU_LH, ALU_LHU: m = off[0];
            ALU_LW:          m = (off != 2'b00);
            default:         m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_lsu_ldu_if.sv
// Load-unit bus bundle: EXU load request/response, store-queue lookup and D-side read channel.
// Latency: n/a (wires only).
// Backpressure: ld_valid held until ld_ready; AR valid/ready; R valid/ready.
interface ysyx_lsu_ldu_if;
    import ysyx_lsu_pkg::*;

    // EXU side
    logic            ld_valid;
    logic [XLEN-1:0] ld_addr;
    logic [4:0]      ld_alu;
    logic [XLEN-1:0] ld_pc;
    logic            ld_ready;
    logic [XLEN-1:0] ld_rdata;
    logic            ld_fault;
    // store-queue lookup
    logic [XLEN-1:0] sq_raddr;
    logic            sq_hit;
    logic [XLEN-1:0] sq_rdata;
    // memory read channel
    logic            mem_arvalid;
    logic [XLEN-1:0] mem_araddr;
    logic            mem_arready;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic [1:0]      mem_rresp;
    logic            mem_rready;

    // Environment view: EXU, store queue and memory together.
    modport master (
        output ld_valid, ld_addr, ld_alu, ld_pc,
        input  ld_ready, ld_rdata, ld_fault,
        input  sq_raddr,
        output sq_hit, sq_rdata,
        input  mem_arvalid, mem_araddr, mem_rready,
        output mem_arready, mem_rvalid, mem_rdata, mem_rresp
    );

    // Load-unit view.
    modport slave (
        input  ld_valid, ld_addr, ld_alu, ld_pc,
        output ld_ready, ld_rdata, ld_fault,
        output sq_raddr,
        input  sq_hit, sq_rdata,
        output mem_arvalid, mem_araddr, mem_rready,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rresp
    );

endinterface

// File: rtl/ysyx_lsu_ld_align.sv
// Combinational load align/extend of the selected word (forwarded or from memory).
// Latency: 0 cycles.
// Backpressure: none.
module ysyx_lsu_ld_align
    import ysyx_lsu_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [4:0]      alu,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] rdata
);

    assign rdata = ld_extend(word, alu, off);

endmodule

// File: rtl/ysyx_lsu_ldu.sv
// Load responder: serves the in-order load at the EXU IOQ head from the store queue or memory.
// Latency: 1 cycle on store-queue hit or misalign fault; otherwise AR wait + R wait + 3 cycles.
// Backpressure: ld_valid held until the 1-cycle ld_ready pulse; AR held until mem_arready.
// Ports: clock, reset (sync, active-high), flush (pipeline kill), bus (ysyx_lsu_ldu_if.slave).
module ysyx_lsu_ldu
    import ysyx_lsu_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    ysyx_lsu_ldu_if.slave bus
);

    ldu_state_e      state_q, state_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [4:0]      req_alu_q, req_alu_d;
    logic [XLEN-1:0] word_q, word_d;
    logic            fault_q, fault_d;
    logic            kill_q, kill_d;

    logic            misaligned;
    logic [XLEN-1:0] ext_word;
    logic            resp_fire;

    // The PC travels with the load for trace only; nothing in the load path consumes it.
    logic unused_pc;
    assign unused_pc = ^bus.ld_pc;

    assign misaligned   = ld_misaligned(bus.ld_alu, bus.ld_addr[1:0]);
    assign bus.sq_raddr = {bus.ld_addr[XLEN-1:2], 2'b00};

    ysyx_lsu_ld_align u_align (
        .word  (word_q),
        .alu   (req_alu_q),
        .off   (req_addr_q[1:0]),
        .rdata (ext_word)
    );

    // Response data and fault are only driven during the pulse so idle outputs stay 0.
    assign bus.ld_ready = resp_fire;
    assign bus.ld_rdata = resp_fire ? ext_word : '0;
    assign bus.ld_fault = resp_fire & fault_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= LDU_IDLE;
            req_addr_q <= '0;
            req_alu_q  <= '0;
            word_q     <= '0;
            fault_q    <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            req_alu_q  <= req_alu_d;
            word_q     <= word_d;
            fault_q    <= fault_d;
            kill_q     <= kill_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_addr_d      = req_addr_q;
        req_alu_d       = req_alu_q;
        word_d          = word_q;
        fault_d         = fault_q;
        kill_d          = kill_q;
        resp_fire       = 1'b0;
        bus.mem_arvalid = 1'b0;
        bus.mem_araddr  = '0;
        bus.mem_rready  = 1'b0;

        case (state_q)
            LDU_IDLE: begin
                // A flush in this cycle also kills whatever ld_valid shows.
                if (bus.ld_valid && !flush) begin
                    req_addr_d = bus.ld_addr;
                    req_alu_d  = bus.ld_alu;
                    kill_d     = 1'b0;
                    if (misaligned) begin
                        word_d  = '0;
                        fault_d = 1'b1;
                        state_d = LDU_RESP;
                    end else if (bus.sq_hit) begin
                        word_d  = bus.sq_rdata;
                        fault_d = 1'b0;
                        state_d = LDU_RESP;
                    end else begin
                        state_d = LDU_ADDR;
                    end
                end
            end

            LDU_ADDR: begin
                // AR cannot be retracted, so a flush here only marks the beat for discard.
                bus.mem_arvalid = 1'b1;
                bus.mem_araddr  = {req_addr_q[XLEN-1:2], 2'b00};
                if (flush) kill_d = 1'b1;
                if (bus.mem_arready) state_d = LDU_DATA;
            end

            LDU_DATA: begin
                bus.mem_rready = 1'b1;
                if (bus.mem_rvalid) begin
                    word_d  = bus.mem_rdata;
                    fault_d = |bus.mem_rresp;
                    // Beat consumed this cycle: a flush now needs no drain.
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        state_d = LDU_IDLE;
                    end else begin
                        state_d = LDU_RESP;
                    end
                end else if (flush) begin
                    state_d = LDU_DRAIN;
                end
            end

            LDU_DRAIN: begin
                bus.mem_rready = 1'b1;
                if (bus.mem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = LDU_IDLE;
                end
            end

            LDU_RESP: begin
                resp_fire = !flush;
                state_d   = LDU_IDLE;
            end

            default: state_d = LDU_IDLE;
        endcase
    end

endmodule
